// File: rtl/dual_xor_pkg.sv
// Shared types and constants for the dual XOR stream cipher and its config sequencer.
// Holds the sequencer state encoding, the config word width function and cipher defaults.
package dual_xor_pkg;

   // Default LFSR width of the cipher
   localparam int DEF_M = 32;

   // Config word: a_mux, d_en, tx taps, tx state, rx taps, rx state
   function automatic int cfg_width(input int m);
      return 4 * m + 2;
   endfunction

   localparam int DEF_W = cfg_width(DEF_M);

   // Cipher power-on defaults
   localparam logic DEF_A_MUX = 1'b0;
   localparam logic DEF_D_EN  = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_RUN    = 2'd3
   } seq_state_e;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register producing the serial config stream, LSB first.
// Ports: clk, rst_n, load_i (capture data_i), shift_i (shift right), data_i, bit_o (= bit 0).
module piso_shift #(
   parameter int W = 18
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [W-1:0] data_i,
   output logic         bit_o
);

   logic [W-1:0] sr_q;
   logic [W-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load_i) begin
         sr_d = data_i;
      end else if (shift_i) begin
         sr_d = {1'b0, sr_q[W-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign bit_o = sr_q[0];

endmodule

// File: rtl/dual_xor_cfg_sequencer.sv
// Serially loads a config word into the dual XOR cipher while reading back its prior config,
// then gates the TX/RX keystream enables. Ports: cfg handshake, stop, tx/rx requests, serial
// cfg link (cfg_en, cfg_i, cfg_o), keystream enables, busy, done pulse and readback word.
module dual_xor_cfg_sequencer
   import dual_xor_pkg::*;
#(
   parameter  int M = DEF_M,
   localparam int W = cfg_width(M)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [W-1:0] cfg_data,
   input  logic         stop,
   input  logic         tx_req,
   input  logic         rx_req,
   input  logic         cfg_o,
   output logic         cfg_en,
   output logic         cfg_i,
   output logic         tx_en,
   output logic         rx_en,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] readback
);

   localparam int CW = $clog2(W);

   seq_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic         cfg_en_q, tx_en_q, rx_en_q;
   logic         busy_q, done_q;
   logic [W-1:0] rb_q, rb_d;
   logic         hs;
   logic         sr_load, sr_shift;

   assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
   assign hs        = cfg_valid && cfg_ready;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_load  = 1'b0;
      sr_shift = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (hs) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
               sr_load = 1'b1;
            end
         end
         ST_LOAD: begin
            sr_shift = 1'b1;
            if (cnt_q == CW'(W - 1)) begin
               state_d = ST_SETTLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_SETTLE: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            // A new config beats a simultaneous stop
            if (hs) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
               sr_load = 1'b1;
            end else if (stop) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Old config enters at the MSB so the first bit out lands at bit 0
   always_comb begin
      rb_d = rb_q;
      if (cfg_en_q) begin
         rb_d = {cfg_o, rb_q[W-1:1]};
      end
   end

   // Outputs are decoded from the next state so they line up with state_q
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         cfg_en_q <= 1'b0;
         tx_en_q  <= 1'b0;
         rx_en_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rb_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cfg_en_q <= (state_d == ST_LOAD);
         tx_en_q  <= (state_d == ST_RUN) && tx_req;
         rx_en_q  <= (state_d == ST_RUN) && rx_req;
         busy_q   <= (state_d == ST_LOAD) || (state_d == ST_SETTLE);
         done_q   <= (state_d == ST_SETTLE);
         rb_q     <= rb_d;
      end
   end

   piso_shift #(
      .W(W)
   ) u_piso (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (sr_load),
      .shift_i(sr_shift),
      .data_i (cfg_data),
      .bit_o  (cfg_i)
   );

   assign cfg_en   = cfg_en_q;
   assign tx_en    = tx_en_q;
   assign rx_en    = rx_en_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign readback = rb_q;

endmodule

// File: tb/tb_dual_xor_cfg_sequencer.sv
// Self-checking bench for dual_xor_cfg_sequencer with M=4 (W=18).
// A model cipher shifts cfg_i in at the MSB and presents its bit 0 on cfg_o.
module tb_dual_xor_cfg_sequencer;

   localparam int M = 4;
   localparam int W = 18;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cfg_valid = 1'b0;
   logic         stop = 1'b0;
   logic         tx_req = 1'b0;
   logic         rx_req = 1'b0;
   logic [W-1:0] cfg_data = '0;
   logic         cfg_o;
   logic         cfg_ready, cfg_en, cfg_i, tx_en, rx_en, busy, done;
   logic [W-1:0] readback;
   logic [W-1:0] cip = 18'h15555;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign cfg_o = cip[0];

   always @(posedge clk) begin
      if (cfg_en) cip <= {cfg_i, cip[W-1:1]};
   end

   dual_xor_cfg_sequencer #(
      .M(M)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_data (cfg_data),
      .stop     (stop),
      .tx_req   (tx_req),
      .rx_req   (rx_req),
      .cfg_o    (cfg_o),
      .cfg_en   (cfg_en),
      .cfg_i    (cfg_i),
      .tx_en    (tx_en),
      .rx_en    (rx_en),
      .busy     (busy),
      .done     (done),
      .readback (readback)
   );

   // Full load: handshake in cycle T, cfg_en over T+1..T+18, done at T+19, RUN at T+20.
   task automatic do_load(input logic [W-1:0] d, input bit with_stop, input bit hold);
      logic [W-1:0] prior;
      @(negedge clk);
      checks++;
      if (cfg_ready !== 1'b1) begin
         failures++;
         $display("FAIL hs_ready got=%b exp=1", cfg_ready);
      end
      cfg_valid = 1'b1;
      cfg_data  = d;
      stop      = with_stop;
      prior     = cip;
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         if (!hold) cfg_valid = 1'b0;
         stop = 1'b0;
         checks++;
         if (cfg_en !== 1'b1 || cfg_i !== d[k]) begin
            failures++;
            $display("FAIL load_bit%0d cfg_en=%b cfg_i=%b exp_en=1 exp_i=%b",
                     k, cfg_en, cfg_i, d[k]);
         end
         checks++;
         if (tx_en !== 1'b0 || rx_en !== 1'b0 || cfg_ready !== 1'b0 ||
             busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL load_ctl%0d tx=%b rx=%b rdy=%b busy=%b done=%b exp=0,0,0,1,0",
                     k, tx_en, rx_en, cfg_ready, busy, done);
         end
      end
      @(negedge clk);
      checks++;
      if (cfg_en !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || cfg_ready !== 1'b0 ||
          tx_en !== 1'b0 || rx_en !== 1'b0) begin
         failures++;
         $display("FAIL settle en=%b done=%b busy=%b rdy=%b tx=%b rx=%b exp=0,1,1,0,0,0",
                  cfg_en, done, busy, cfg_ready, tx_en, rx_en);
      end
      checks++;
      if (readback !== prior) begin
         failures++;
         $display("FAIL readback got=%h exp=%h", readback, prior);
      end
      @(negedge clk);
      checks++;
      if (cfg_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
         failures++;
         $display("FAIL run_entry en=%b done=%b busy=%b rdy=%b exp=0,0,0,1",
                  cfg_en, done, busy, cfg_ready);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (cfg_en !== 0 || cfg_i !== 0 || tx_en !== 0 || rx_en !== 0 ||
          busy !== 0 || done !== 0 || readback !== '0 || cfg_ready !== 1) begin
         failures++;
         $display("FAIL reset en=%b i=%b tx=%b rx=%b busy=%b done=%b rb=%h rdy=%b",
                  cfg_en, cfg_i, tx_en, rx_en, busy, done, readback, cfg_ready);
      end
      @(negedge clk);
      rst_n  = 1'b1;
      tx_req = 1'b1;
      rx_req = 1'b1;
      stop   = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (tx_en !== 0 || rx_en !== 0 || busy !== 0 || cfg_en !== 0) begin
            failures++;
            $display("FAIL idle_quiet tx=%b rx=%b busy=%b en=%b exp=0",
                     tx_en, rx_en, busy, cfg_en);
         end
      end
      tx_req = 1'b0;
      rx_req = 1'b0;
      stop   = 1'b0;
   endtask

   task automatic test_first_load();
      do_load(18'h2A5C3, 1'b0, 1'b0);
   endtask

   task automatic test_run_random();
      logic ptx, prx;
      ptx = 1'b0;
      prx = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tx_req = 1'($urandom);
         rx_req = 1'($urandom);
         ptx = tx_req;
         prx = rx_req;
         @(negedge clk);
         checks++;
         if (tx_en !== ptx || rx_en !== prx || cfg_en !== 1'b0) begin
            failures++;
            $display("FAIL run_en%0d tx=%b rx=%b en=%b exp_tx=%b exp_rx=%b",
                     i, tx_en, rx_en, cfg_en, ptx, prx);
         end
      end
   endtask

   task automatic test_run_stop();
      tx_req = 1'b1;
      rx_req = 1'b0;
      @(negedge clk);
      checks++;
      if (tx_en !== 1'b1 || rx_en !== 1'b0) begin
         failures++;
         $display("FAIL run_tx tx=%b rx=%b exp=1,0", tx_en, rx_en);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      repeat (2) begin
         checks++;
         if (tx_en !== 0 || rx_en !== 0 || cfg_en !== 0 || busy !== 0) begin
            failures++;
            $display("FAIL stop_idle tx=%b rx=%b en=%b busy=%b exp=0",
                     tx_en, rx_en, cfg_en, busy);
         end
         @(negedge clk);
      end
      tx_req = 1'b0;
   endtask

   task automatic test_stop_with_handshake();
      logic [W-1:0] d;
      d = W'($urandom);
      do_load(W'($urandom), 1'b0, 1'b0);
      tx_req = 1'b1;
      rx_req = 1'b1;
      @(negedge clk);
      checks++;
      if (tx_en !== 1'b1 || rx_en !== 1'b1) begin
         failures++;
         $display("FAIL pre_stop tx=%b rx=%b exp=1,1", tx_en, rx_en);
      end
      do_load(d, 1'b1, 1'b0);
      tx_req = 1'b0;
      rx_req = 1'b0;
   endtask

   task automatic test_reset_mid_load();
      logic [W-1:0] d;
      d = W'($urandom);
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_data  = d;
      @(negedge clk);
      cfg_valid = 1'b0;
      repeat (7) @(negedge clk);
      checks++;
      if (cfg_en !== 1'b1 || cfg_i !== d[7]) begin
         failures++;
         $display("FAIL mid_bit7 en=%b i=%b exp_i=%b", cfg_en, cfg_i, d[7]);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (cfg_en !== 0 || cfg_i !== 0 || tx_en !== 0 || rx_en !== 0 ||
          busy !== 0 || done !== 0 || readback !== '0 || cfg_ready !== 1) begin
         failures++;
         $display("FAIL mid_reset en=%b i=%b tx=%b rx=%b busy=%b done=%b rb=%h rdy=%b",
                  cfg_en, cfg_i, tx_en, rx_en, busy, done, readback, cfg_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_load(W'($urandom), 1'b0, 1'b0);
   endtask

   task automatic test_hold_valid();
      int en_cnt;
      bit fin;
      do_load(W'($urandom), 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (cfg_en !== 1'b1) begin
         failures++;
         $display("FAIL hold_second_load en=%b exp=1", cfg_en);
      end
      cfg_valid = 1'b0;
      en_cnt = (cfg_en === 1'b1) ? 1 : 0;
      fin = 1'b0;
      for (int i = 0; i < 40 && !fin; i++) begin
         @(negedge clk);
         if (cfg_en === 1'b1) en_cnt++;
         if (done === 1'b1) fin = 1'b1;
      end
      checks++;
      if (!fin || en_cnt != W) begin
         failures++;
         $display("FAIL hold_second_len fin=%b cycles=%0d exp=%0d", fin, en_cnt, W);
      end
   endtask

   task automatic test_random_loads();
      for (int i = 0; i < 4; i++) begin
         do_load(W'($urandom), 1'b0, 1'b0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_first_load();
      test_run_random();
      test_run_stop();
      test_stop_with_handshake();
      test_reset_mid_load();
      test_hold_valid();
      test_random_loads();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
